// File: rtl/pe_column_accumulator.sv
// Column-bottom accumulator: sums num_tiles active partial sums per job and queues results in a small FIFO.
// Optional ACC_SATURATE_EN clamps the sum on carry-out instead of wrapping.
module pe_column_accumulator #(
    parameter int IN_W       = 16,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       num_tiles,
    input  logic             active,
    input  logic [IN_W-1:0]  maccout,
    output logic             busy,
    output logic             stall,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             drop_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          tgt_q, tgt_d;
    logic                overflow_q, overflow_d;
    logic                drop_err_q, drop_err_d;

    logic [ACC_W:0]      sum_wide;
    logic                carry;
    logic [ACC_W-1:0]    sum;

    logic [ACC_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q;
    logic                push, pop, full, room;
    logic [ACC_W-1:0]    push_data;

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, maccout};
    assign carry    = sum_wide[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, acc is all-ones, so any further nonzero sample carries again and stays clamped.
    assign sum = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum = sum_wide[ACC_W-1:0];
`endif

    assign result_valid = (fifo_cnt_q != '0);
    assign pop          = result_valid & result_ready;
    assign full         = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign room         = ~full | pop;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        overflow_d = overflow_q;
        drop_err_d = drop_err_q;
        push       = 1'b0;
        push_data  = sum;
        case (state_q)
            S_IDLE: begin
                if (active) drop_err_d = 1'b1;
                if (start) begin
                    tgt_d   = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (active) begin
                    cnt_d = cnt_q + 8'd1;
                    if (carry) overflow_d = 1'b1;
                    if (cnt_q == tgt_q - 8'd1) begin
                        if (room) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            acc_d   = sum;
                            state_d = S_HOLD;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            S_HOLD: begin
                if (active) drop_err_d = 1'b1;
                if (room) begin
                    push      = 1'b1;
                    push_data = acc_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= 8'd0;
            tgt_q      <= 8'd0;
            overflow_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            overflow_q <= overflow_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    // Stale RAM contents are masked so the head reads zero whenever the FIFO is empty.
    assign result   = result_valid ? mem[rd_ptr_q] : '0;
    assign busy     = (state_q != S_IDLE);
    assign stall    = (state_q == S_HOLD);
    assign overflow = overflow_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_pe_column_accumulator.sv
// Directed bench for pe_column_accumulator: a 24-bit instance for the job/FIFO flow and
// a 16-bit instance for the carry-out behaviour.
module tb_pe_column_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, active, result_ready;
    logic [7:0]  num_tiles;
    logic [15:0] maccout;
    logic        busy, stall, result_valid, overflow, drop_err;
    logic [23:0] result;

    logic        start_b, active_b, ready_b;
    logic [7:0]  num_tiles_b;
    logic [15:0] maccout_b;
    logic        busy_b, stall_b, valid_b, overflow_b, drop_err_b;
    logic [15:0] result_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_column_accumulator #(.IN_W(16), .ACC_W(24), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .active(active), .maccout(maccout), .busy(busy), .stall(stall),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .overflow(overflow), .drop_err(drop_err)
    );

    pe_column_accumulator #(.IN_W(16), .ACC_W(16), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_tiles(num_tiles_b),
        .active(active_b), .maccout(maccout_b), .busy(busy_b), .stall(stall_b),
        .result(result_b), .result_valid(valid_b), .result_ready(ready_b),
        .overflow(overflow_b), .drop_err(drop_err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic one_sample_job(input logic [15:0] v);
        start = 1'b1; num_tiles = 8'd1;
        step();
        start = 1'b0; active = 1'b1; maccout = v;
        step();
        active = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; active = 1'b0; result_ready = 1'b0;
        num_tiles = 8'd0; maccout = 16'd0;
        start_b = 1'b0; active_b = 1'b0; ready_b = 1'b0;
        num_tiles_b = 8'd0; maccout_b = 16'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy",     busy,         1'b0);
        chk("rst_stall",    stall,        1'b0);
        chk("rst_valid",    result_valid, 1'b0);
        chk("rst_result",   result,       24'd0);
        chk("rst_overflow", overflow,     1'b0);
        chk("rst_drop_err", drop_err,     1'b0);

        // 1: four samples summed
        result_ready = 1'b1;
        start = 1'b1; num_tiles = 8'd4;
        step();
        start = 1'b0;
        chk("t1_busy_accum", busy, 1'b1);
        active = 1'b1;
        maccout = 16'd10; step();
        maccout = 16'd20; step();
        maccout = 16'd30; step();
        chk("t1_no_early_valid", result_valid, 1'b0);
        maccout = 16'd40; step();
        active = 1'b0;
        chk("t1_valid", result_valid, 1'b1);
        chk("t1_result", result, 24'd100);
        chk("t1_busy_done", busy, 1'b0);
        step();
        chk("t1_popped", result_valid, 1'b0);

        // 2: num_tiles=0 behaves as one sample; the next active is dropped
        result_ready = 1'b0;
        start = 1'b1; num_tiles = 8'd0;
        step();
        start = 1'b0; active = 1'b1; maccout = 16'hFFFF;
        step();
        chk("t2_result", result, 24'h00FFFF);
        chk("t2_busy", busy, 1'b0);
        maccout = 16'h0005;
        step();
        active = 1'b0;
        chk("t2_drop_err", drop_err, 1'b1);
        chk("t2_result_held", result, 24'h00FFFF);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("t2_empty", result_valid, 1'b0);

        // 3: FIFO fills, fifth job waits in HOLD
        for (int v = 1; v <= 4; v++) one_sample_job(16'(v));
        chk("t3_head1", result, 24'd1);
        chk("t3_not_stalled", stall, 1'b0);
        one_sample_job(16'd5);
        chk("t3_stall", stall, 1'b1);
        chk("t3_busy_hold", busy, 1'b1);
        active = 1'b1;
        step();
        active = 1'b0;
        chk("t3_still_stall", stall, 1'b1);
        chk("t3_hold_drop_err", drop_err, 1'b1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("t3_stall_clear", stall, 1'b0);
        chk("t3_head2", result, 24'd2);

        // 4: FIFO full but popping in the same cycle -> direct push
        start = 1'b1; num_tiles = 8'd1;
        step();
        start = 1'b0; active = 1'b1; maccout = 16'd7; result_ready = 1'b1;
        step();
        active = 1'b0;
        chk("t4_no_hold", stall, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_head3", result, 24'd3);
        step(); chk("t4_head4", result, 24'd4);
        step(); chk("t4_head5", result, 24'd5);
        step(); chk("t4_head7", result, 24'd7);
        step(); chk("t4_drained", result_valid, 1'b0);
        result_ready = 1'b0;

        // 5: 16-bit accumulator carry-out
        start_b = 1'b1; num_tiles_b = 8'd2;
        step();
        start_b = 1'b0; active_b = 1'b1; maccout_b = 16'hFFFF;
        step();
        chk("t5_no_ovf_yet", overflow_b, 1'b0);
        maccout_b = 16'h0002;
        step();
        active_b = 1'b0;
        chk("t5_overflow", overflow_b, 1'b1);
        chk("t5_valid", valid_b, 1'b1);
`ifdef ACC_SATURATE_EN
        chk("t5_result", result_b, 16'hFFFF);
`else
        chk("t5_result", result_b, 16'h0001);
`endif

        // 6: reset mid-job with two entries queued
        one_sample_job(16'd9);
        one_sample_job(16'd11);
        chk("t6_head", result, 24'd9);
        start = 1'b1; num_tiles = 8'd3;
        step();
        start = 1'b0; active = 1'b1; maccout = 16'd50;
        step();
        active = 1'b0;
        chk("t6_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", busy, 1'b0);
        chk("t6_valid", result_valid, 1'b0);
        chk("t6_result", result, 24'd0);
        chk("t6_drop_err", drop_err, 1'b0);
        chk("t6_overflow_b", overflow_b, 1'b0);
        chk("t6_valid_b", valid_b, 1'b0);
        start = 1'b1; num_tiles = 8'd2;
        step();
        start = 1'b0; active = 1'b1; maccout = 16'd5;
        step();
        maccout = 16'd6;
        step();
        active = 1'b0;
        chk("t6_new_result", result, 24'd11);
        chk("t6_new_valid", result_valid, 1'b1);
        chk("t6_new_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
